// File: rtl/ti3_speck_bitserial_param.sv
// rtl/ti3_speck_bitserial_param.sv - three-share TI Speck core, bit-serial LSB-first, parametrised word/key/rounds
// One share slice per instance; slices exchange only next-share operand and carry bits.

module ti3_speck_share #(
   parameter int WORD_W    = 64,
   parameter int KEY_WORDS = 2,
   parameter int ALPHA     = 8,
   parameter int BETA      = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load_pt_i,
   input  logic                      load_key_i,
   input  logic                      din_i,
   input  logic                      kin_i,
   input  logic                      seed_i,
   input  logic                      rnd_i,
   input  logic                      krnd_i,
   input  logic                      compute_i,
   input  logic                      commit_i,
   input  logic                      unload_i,
   input  logic [$clog2(WORD_W)-1:0] bit_i,
   input  logic                      rc_i,
   output logic                      dx_o,
   output logic                      dy_o,
   output logic                      dc_o,
   output logic                      kx_o,
   output logic                      ky_o,
   output logic                      kc_o,
   input  logic                      nx_i,
   input  logic                      ny_i,
   input  logic                      nc_i,
   input  logic                      nkx_i,
   input  logic                      nky_i,
   input  logic                      nkc_i,
   output logic [1:0]                dout_o
);

   localparam int W  = WORD_W;
   localparam int KW = KEY_WORDS * WORD_W;
   localparam int IW = $clog2(WORD_W);

   logic [2*W-1:0] pt_q;
   logic [KW-1:0]  key_q;
   logic [KW-1:0]  key_d;
   logic [W-1:0]   xn_q, yn_q, kn_q, ln_q;
   logic           c_q, kc_q;
   logic [W-1:0]   x_w, y_w, k_w, l_w;
   logic [IW-1:0]  ia, ib;
   logic           x_bit, y_bit, l_bit, k_bit;
   int             ra, rb;

   // Three-share maj(a,b,c): own-share and next-share cross terms cover all nine products.
   function automatic logic tmaj(input logic a, input logic b, input logic c,
                                 input logic an, input logic bn, input logic cn);
      return (a & b) ^ (a & bn) ^ (an & b) ^
             (a & c) ^ (a & cn) ^ (an & c) ^
             (b & c) ^ (b & cn) ^ (bn & c);
   endfunction

   assign x_w = pt_q[2*W-1:W];
   assign y_w = pt_q[W-1:0];
   assign k_w = key_q[W-1:0];
   assign l_w = key_q[2*W-1:W];

   always_comb begin
      ra = int'(bit_i) + ALPHA;
      if (ra >= W) ra = ra - W;
      rb = int'(bit_i) + W - BETA;
      if (rb >= W) rb = rb - W;
      ia = IW'(ra);
      ib = IW'(rb);
   end

   assign dx_o = x_w[ia];
   assign dy_o = y_w[bit_i];
   assign dc_o = c_q;
   assign kx_o = l_w[ia];
   assign ky_o = k_w[bit_i];
   assign kc_o = kc_q;

   assign x_bit = dx_o ^ dy_o ^ c_q ^ k_w[bit_i];
   assign y_bit = y_w[ib] ^ x_bit;
   assign l_bit = kx_o ^ ky_o ^ kc_q ^ rc_i;
   assign k_bit = k_w[ib] ^ l_bit;

   // l FIFO advances: head l0 drops out, fresh l enters the tail, new k sits at the bottom.
   always_comb begin
      key_d        = {ln_q, key_q[KW-1:W]};
      key_d[W-1:0] = kn_q;
   end

   assign dout_o = unload_i ? {x_w[0], y_w[0]} : 2'b00;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pt_q  <= '0;
         key_q <= '0;
         xn_q  <= '0;
         yn_q  <= '0;
         kn_q  <= '0;
         ln_q  <= '0;
         c_q   <= 1'b0;
         kc_q  <= 1'b0;
      end else begin
         if (load_pt_i)
            pt_q <= {din_i, pt_q[2*W-1:1]};
         if (load_key_i)
            key_q <= {kin_i, key_q[KW-1:1]};
         if (seed_i) begin
            c_q  <= rnd_i;
            kc_q <= krnd_i;
         end else if (compute_i) begin
            c_q  <= tmaj(dx_o, dy_o, c_q, nx_i, ny_i, nc_i);
            kc_q <= tmaj(kx_o, ky_o, kc_q, nkx_i, nky_i, nkc_i);
         end
         if (compute_i) begin
            xn_q[bit_i] <= x_bit;
            yn_q[bit_i] <= y_bit;
            kn_q[bit_i] <= k_bit;
            ln_q[bit_i] <= l_bit;
         end
         if (commit_i) begin
            pt_q  <= {xn_q, yn_q};
            key_q <= key_d;
         end
         if (unload_i)
            pt_q <= {1'b0, pt_q[2*W-1:W+1], 1'b0, pt_q[W-1:1]};
      end
   end

endmodule

module ti3_speck_bitserial_param #(
   parameter int WORD_W    = 64,
   parameter int KEY_WORDS = 2,
   parameter int ROUNDS    = 32,
   parameter int ALPHA     = 8,
   parameter int BETA      = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_pt,
   input  logic       load_key,
   input  logic       din_a,
   input  logic       din_b,
   input  logic       din_c,
   input  logic       kin_a,
   input  logic       kin_b,
   input  logic       kin_c,
   input  logic       rnd_a,
   input  logic       rnd_b,
   input  logic       rnd_c,
   input  logic       krnd_a,
   input  logic       krnd_b,
   input  logic       krnd_c,
   input  logic       start,
   output logic       busy,
   output logic       out_valid,
   output logic [1:0] dout_a,
   output logic [1:0] dout_b,
   output logic [1:0] dout_c,
   output logic       done
);

   localparam int CW = $clog2(WORD_W + 1);
   localparam int IW = $clog2(WORD_W);
   localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
   localparam logic [CW-1:0] BIT_TURN     = CW'(WORD_W);
   localparam logic [CW-1:0] BIT_OUT_LAST = CW'(WORD_W - 1);
   localparam logic [RW-1:0] ROUND_LAST   = RW'(ROUNDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT} state_t;

   state_t          state_q;
   logic [CW-1:0]   bit_q;
   logic [RW-1:0]   round_q;
   logic            busy_q, out_valid_q, done_q;

   logic            idle, go, ld_pt, ld_key, compute, turn, seed, rc_bit;
   logic [IW-1:0]   bit_idx;
   logic [WORD_W-1:0] rc_word;
   logic [2:0]      din_w, kin_w, rnd_w, krnd_w;
   logic [2:0]      dx_w, dy_w, dc_w, kx_w, ky_w, kc_w;
   logic [1:0]      dout_w [3];

   assign idle    = (state_q == S_IDLE);
   assign go      = idle & start;
   assign ld_pt   = idle & load_pt & ~start;
   assign ld_key  = idle & load_key & ~start;
   assign compute = (state_q == S_RUN) && (bit_q != BIT_TURN);
   assign turn    = (state_q == S_RUN) && (bit_q == BIT_TURN);
   assign seed    = go | turn;
   assign bit_idx = bit_q[IW-1:0];

   // Round index doubles as the key-schedule constant, serialised LSB-first.
   assign rc_word = WORD_W'(round_q);
   assign rc_bit  = rc_word[bit_idx];

   assign din_w  = {din_c, din_b, din_a};
   assign kin_w  = {kin_c, kin_b, kin_a};
   assign rnd_w  = {rnd_c, rnd_b, rnd_a};
   assign krnd_w = {krnd_c, krnd_b, krnd_a};

   for (genvar s = 0; s < 3; s++) begin : g_share
      ti3_speck_share #(
         .WORD_W   (WORD_W),
         .KEY_WORDS(KEY_WORDS),
         .ALPHA    (ALPHA),
         .BETA     (BETA)
      ) u_share (
         .clk       (clk),
         .rst       (rst),
         .load_pt_i (ld_pt),
         .load_key_i(ld_key),
         .din_i     (din_w[s]),
         .kin_i     (kin_w[s]),
         .seed_i    (seed),
         .rnd_i     (rnd_w[s]),
         .krnd_i    (krnd_w[s]),
         .compute_i (compute),
         .commit_i  (turn),
         .unload_i  (out_valid_q),
         .bit_i     (bit_idx),
         .rc_i      ((s == 0) ? rc_bit : 1'b0),
         .dx_o      (dx_w[s]),
         .dy_o      (dy_w[s]),
         .dc_o      (dc_w[s]),
         .kx_o      (kx_w[s]),
         .ky_o      (ky_w[s]),
         .kc_o      (kc_w[s]),
         .nx_i      (dx_w[(s+1)%3]),
         .ny_i      (dy_w[(s+1)%3]),
         .nc_i      (dc_w[(s+1)%3]),
         .nkx_i     (kx_w[(s+1)%3]),
         .nky_i     (ky_w[(s+1)%3]),
         .nkc_i     (kc_w[(s+1)%3]),
         .dout_o    (dout_w[s])
      );
   end

   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign done      = done_q;
   assign dout_a    = dout_w[0];
   assign dout_b    = dout_w[1];
   assign dout_c    = dout_w[2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         bit_q       <= '0;
         round_q     <= '0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_RUN;
                  busy_q  <= 1'b1;
                  bit_q   <= '0;
                  round_q <= '0;
               end
            end
            S_RUN: begin
               if (bit_q == BIT_TURN) begin
                  bit_q <= '0;
                  if (round_q == ROUND_LAST) begin
                     state_q     <= S_OUT;
                     out_valid_q <= 1'b1;
                     round_q     <= '0;
                  end else begin
                     round_q <= round_q + 1'b1;
                  end
               end else begin
                  bit_q <= bit_q + 1'b1;
               end
            end
            S_OUT: begin
               if (bit_q == BIT_OUT_LAST) begin
                  state_q     <= S_IDLE;
                  bit_q       <= '0;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b0;
                  done_q      <= 1'b1;
               end else begin
                  bit_q <= bit_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
